rf_write_arbiter: RTL and testbench

Shares the register file's single write port between the in-order pipeline writeback stage (WB) and one multi-cycle execution unit (MC, e.g. a divider). It buffers MC results in a 2-entry FIFO and keeps a per-register pending scoreboard, so decode can stall on hazards against in-flight MC destinations. A starvation counter forces MC onto the port when it has waited too long. The block sits between the WB/MC result buses and the register file write inputs (`rd`, `rd_din`, `write_enable`).

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_write_arbiter_if.sv | 37 +++
 rtl/rf_write_arbiter_fifo.sv | 60 ++++++
 rtl/rf_write_arbiter.sv | 114 +++++++++++
 tb/tb_rf_write_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types: write-request payload and write-port grant encoding.
package rf_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } rf_wreq_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_MC
    } grant_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of WB/MC result buses, issue/decode hazard signals and the register file write port.
interface rf_write_arbiter_if;
    import rf_pkg::*;

    logic             wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             wb_hold;

    logic             mc_valid;
    logic [REG_W-1:0] mc_rd;
    logic [XLEN-1:0]  mc_data;
    logic             mc_ready;

    logic             iss_valid;
    logic [REG_W-1:0] iss_rd;
    logic [REG_W-1:0] dec_rs1;
    logic [REG_W-1:0] dec_rs2;
    logic             hazard;

    logic             rf_we;
    logic [REG_W-1:0] rf_rd;
    logic [XLEN-1:0]  rf_din;

    modport master (
        output wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
               iss_valid, iss_rd, dec_rs1, dec_rs2,
        input  wb_hold, mc_ready, hazard, rf_we, rf_rd, rf_din
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
               iss_valid, iss_rd, dec_rs1, dec_rs2,
        output wb_hold, mc_ready, hazard, rf_we, rf_rd, rf_din
    );

endinterface

// File: rtl/rf_write_arbiter_fifo.sv
// Small circular FIFO of pending MC write requests; the head is visible combinationally.
module rf_wreq_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  rf_wreq_t push_data,
    input  logic     pop,
    output rf_wreq_t head,
    output logic     empty,
    output logic     full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rf_wreq_t         mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg] <= push_data;
    end

    // The owner must gate pushes with the full flag; a push while full is dropped.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between WB and a buffered multi-cycle unit,
// tracking in-flight MC destinations and forcing MC onto the port after repeated losses.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);

    localparam logic [2:0] STARVE_SET_AT = 3'(STARVE_LIMIT - 1);

    rf_wreq_t        mc_req;
    rf_wreq_t        head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    grant_t          grant;
    logic            starve_inc;
    logic [2:0]      starve_reg;
    logic [2:0]      starve_next;
    logic            force_mc_reg;
    logic            force_mc_next;
    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;

    assign mc_req       = '{rd: bus.mc_rd, data: bus.mc_data};
    assign bus.mc_ready = ~fifo_full;
    assign push         = bus.mc_valid & ~fifo_full & ~reset;
    assign pop          = (grant == GNT_MC);

    rf_wreq_fifo #(.DEPTH(2)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (mc_req),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        grant = GNT_NONE;
        if (!reset) begin
            if (force_mc_reg && !fifo_empty) grant = GNT_MC;
            else if (bus.wb_valid)           grant = GNT_WB;
            else if (!fifo_empty)            grant = GNT_MC;
        end
    end

    always_comb begin
        bus.rf_rd  = '0;
        bus.rf_din = '0;
        case (grant)
            GNT_WB: begin
                bus.rf_rd  = bus.wb_rd;
                bus.rf_din = bus.wb_data;
            end
            GNT_MC: begin
                bus.rf_rd  = head.rd;
                bus.rf_din = head.data;
            end
            default: ;
        endcase
    end

    // A grant to x0 still consumes the request; only the physical write is suppressed.
    assign bus.rf_we   = (grant != GNT_NONE) && (bus.rf_rd != '0);
    assign bus.wb_hold = bus.wb_valid & (grant != GNT_WB) & ~reset;

    always_comb begin
        starve_inc    = (grant == GNT_WB) && !fifo_empty;
        starve_next   = starve_reg;
        force_mc_next = force_mc_reg;
        if (fifo_empty || pop) begin
            starve_next   = '0;
            force_mc_next = 1'b0;
        end else if (starve_inc) begin
            if (starve_reg != 3'd7)            starve_next   = starve_reg + 3'd1;
            if (starve_reg == STARVE_SET_AT)   force_mc_next = 1'b1;
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
        if (gi == 0) begin : g_x0
            assign pending_next[gi] = 1'b0;
        end else begin : g_xn
            assign pending_next[gi] =
                (pending_reg[gi] & ~(pop && (head.rd == REG_W'(gi)))) |
                (bus.iss_valid && (bus.iss_rd == REG_W'(gi)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_reg   <= '0;
            force_mc_reg <= 1'b0;
            pending_reg  <= '0;
        end else begin
            starve_reg   <= starve_next;
            force_mc_reg <= force_mc_next;
            pending_reg  <= pending_next;
        end
    end

    // No bypass of a same-cycle pop: the stall lasts one cycle past the writeback.
    assign bus.hazard = ~reset & (pending_reg[bus.dec_rs1] | pending_reg[bus.dec_rs2] |
                                  (bus.iss_valid & pending_reg[bus.iss_rd]));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a queue-based reference model predicts each cycle,
// a monitor compares on the falling edge.
`timescale 1ns/1ps
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b1;
    logic reset;
    always #5 clk = ~clk;

    rf_write_arbiter_if bus();

    rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int cyc; logic [4:0] rd; logic [31:0] din; } wr_t;
    typedef struct { int cyc; bit in_reset; bit hold; bit hazard; bit ready; } st_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

    wr_t  wr_q[$];
    st_t  st_q[$];
    ent_t m_fifo[$];
    bit [31:0] m_pending;
    int   m_losses;
    bit   m_force;
    bit   m_hold_prev;
    int   cyc_n;
    int   n_checks;
    int   n_fail;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc_n, act, exp);
        end
    endfunction

    // Reference model: one call per cycle, after the inputs for that cycle are driven.
    task automatic model_step();
        st_t s;
        int g;
        bit ne;
        logic [4:0]  grd;
        logic [31:0] gdat;
        s.cyc = cyc_n; s.in_reset = reset; s.hold = 0; s.hazard = 0;
        s.ready = (m_fifo.size() < 2);
        g = 0; grd = '0; gdat = '0;
        if (reset) begin
            m_fifo.delete();
            m_pending = '0; m_losses = 0; m_force = 0;
        end else begin
            ne = (m_fifo.size() > 0);
            s.hazard = m_pending[bus.dec_rs1] | m_pending[bus.dec_rs2] |
                       (bus.iss_valid & m_pending[bus.iss_rd]);
            if (m_force && ne) begin g = 2; s.hold = bus.wb_valid; end
            else if (bus.wb_valid) g = 1;
            else if (ne) g = 2;
            if (g == 1) begin grd = bus.wb_rd; gdat = bus.wb_data; end
            else if (g == 2) begin grd = m_fifo[0].rd; gdat = m_fifo[0].data; end
            if (g != 0 && grd != 0) wr_q.push_back('{cyc_n, grd, gdat});
            if (g == 2) begin
                m_pending[m_fifo[0].rd] = 1'b0;
                void'(m_fifo.pop_front());
                m_losses = 0; m_force = 0;
            end else if (g == 1 && ne) begin
                m_losses++;
                if (m_losses >= LIMIT) m_force = 1;
            end
            if (bus.mc_valid && s.ready) m_fifo.push_back('{bus.mc_rd, bus.mc_data});
            if (bus.iss_valid && bus.iss_rd != 0) m_pending[bus.iss_rd] = 1'b1;
            if (m_fifo.size() == 0) begin m_losses = 0; m_force = 0; end
        end
        m_pending[0] = 1'b0;
        m_hold_prev = s.hold;
        st_q.push_back(s);
    endtask

    // Monitor: pops the per-cycle expectation and any write due this cycle.
    initial begin : monitor
        st_t s;
        wr_t w;
        forever begin
            @(negedge clk);
            if (st_q.size() != 0) begin
                s = st_q.pop_front();
                check("wb_hold", 32'(bus.wb_hold), 32'(s.hold));
                check("hazard", 32'(bus.hazard), 32'(s.hazard));
                if (!s.in_reset) check("mc_ready", 32'(bus.mc_ready), 32'(s.ready));
                if (wr_q.size() != 0 && wr_q[0].cyc == s.cyc) begin
                    w = wr_q.pop_front();
                    check("rf_we", 32'(bus.rf_we), 32'd1);
                    check("rf_rd", 32'(bus.rf_rd), 32'(w.rd));
                    check("rf_din", bus.rf_din, w.din);
                end else begin
                    check("rf_we_idle", 32'(bus.rf_we), 32'd0);
                end
            end
        end
    end

    task automatic half1();
        model_step();
        @(negedge clk);
    endtask

    task automatic half2();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic cyc();
        half1();
        half2();
    endtask

    task automatic idle_inputs();
        bus.wb_valid = 0; bus.wb_rd = '0; bus.wb_data = '0;
        bus.mc_valid = 0; bus.mc_rd = '0; bus.mc_data = '0;
        bus.iss_valid = 0; bus.iss_rd = '0;
        bus.dec_rs1 = '0; bus.dec_rs2 = '0;
    endtask

    task automatic rand_inputs();
        bus.wb_valid = 1'($urandom); bus.wb_rd = 5'($urandom); bus.wb_data = $urandom;
        bus.mc_valid = 1'($urandom); bus.mc_rd = 5'($urandom); bus.mc_data = $urandom;
        bus.iss_valid = 1'($urandom); bus.iss_rd = 5'($urandom);
        bus.dec_rs1 = 5'($urandom); bus.dec_rs2 = 5'($urandom);
    endtask

    initial begin : stim
        n_checks = 0; n_fail = 0; cyc_n = 0;
        m_pending = '0; m_losses = 0; m_force = 0; m_hold_prev = 0;

        // Reset with toggling inputs, then confirm no register is pending.
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            half1();
            check("rst_rf_we", 32'(bus.rf_we), 32'd0);
            check("rst_hazard", 32'(bus.hazard), 32'd0);
            half2();
        end
        reset = 0;
        idle_inputs();
        for (int r = 0; r < 32; r += 2) begin
            bus.dec_rs1 = 5'(r);
            bus.dec_rs2 = 5'(r + 1);
            half1();
            check("post_rst_hazard", 32'(bus.hazard), 32'd0);
            if (r == 0) check("post_rst_ready", 32'(bus.mc_ready), 32'd1);
            half2();
        end
        idle_inputs();

        // WB only, including a write to x0.
        bus.wb_valid = 1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEAD;
        half1();
        check("wb_we", 32'(bus.rf_we), 32'd1);
        check("wb_rd", 32'(bus.rf_rd), 32'd5);
        check("wb_din", bus.rf_din, 32'hDEAD);
        half2();
        bus.wb_rd = 5'd0;
        half1();
        check("wb_x0_we", 32'(bus.rf_we), 32'd0);
        half2();
        idle_inputs();

        // Scoreboard hazard on x7 through issue, push, pop.
        bus.iss_valid = 1; bus.iss_rd = 5'd7;
        cyc();
        bus.iss_valid = 0; bus.dec_rs1 = 5'd7;
        bus.mc_valid = 1; bus.mc_rd = 5'd7; bus.mc_data = 32'h1234;
        half1();
        check("haz_pending", 32'(bus.hazard), 32'd1);
        half2();
        bus.mc_valid = 0;
        half1();
        check("mc_we", 32'(bus.rf_we), 32'd1);
        check("mc_rd", 32'(bus.rf_rd), 32'd7);
        check("mc_din", bus.rf_din, 32'h1234);
        check("haz_on_pop", 32'(bus.hazard), 32'd1);
        half2();
        half1();
        check("haz_cleared", 32'(bus.hazard), 32'd0);
        half2();
        idle_inputs();

        // FIFO full under continuous WB; third push rejected, drain 3 then 4.
        bus.wb_valid = 1; bus.wb_rd = 5'd20; bus.wb_data = 32'hCAFE;
        bus.mc_valid = 1; bus.mc_rd = 5'd3; bus.mc_data = 32'd1;
        cyc();
        bus.mc_rd = 5'd4; bus.mc_data = 32'd2;
        cyc();
        bus.mc_rd = 5'd5; bus.mc_data = 32'd3;
        half1();
        check("full_ready", 32'(bus.mc_ready), 32'd0);
        half2();
        bus.mc_valid = 0;
        repeat (10) cyc();
        idle_inputs();
        repeat (3) cyc();

        // Starvation: one MC entry behind continuous WB.
        bus.wb_valid = 1; bus.wb_rd = 5'd12; bus.wb_data = 32'h100;
        bus.mc_valid = 1; bus.mc_rd = 5'd10; bus.mc_data = 32'hAA;
        cyc();
        bus.mc_valid = 0;
        bus.wb_data++;
        for (int k = 1; k <= 6; k++) begin
            half1();
            if (k <= 4) begin
                check("starve_wb_hold", 32'(bus.wb_hold), 32'd0);
                check("starve_wb_rd", 32'(bus.rf_rd), 32'd12);
            end else if (k == 5) begin
                check("forced_hold", 32'(bus.wb_hold), 32'd1);
                check("forced_rd", 32'(bus.rf_rd), 32'd10);
                check("forced_din", bus.rf_din, 32'hAA);
            end else begin
                check("held_wb_we", 32'(bus.rf_we), 32'd1);
                check("held_wb_rd", 32'(bus.rf_rd), 32'd12);
                check("held_wb_din", bus.rf_din, 32'h105);
            end
            half2();
            if (k != 5) bus.wb_data++;
        end
        idle_inputs();
        cyc();

        // Mid-operation reset with two queued entries and x9 pending.
        bus.wb_valid = 1; bus.wb_rd = 5'd13; bus.wb_data = 32'h55;
        bus.iss_valid = 1; bus.iss_rd = 5'd9;
        bus.mc_valid = 1; bus.mc_rd = 5'd9; bus.mc_data = 32'h99;
        cyc();
        bus.iss_valid = 0;
        bus.mc_rd = 5'd11; bus.mc_data = 32'hBB;
        cyc();
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            half1();
            check("midrst_rf_we", 32'(bus.rf_we), 32'd0);
            half2();
        end
        reset = 0;
        idle_inputs();
        bus.dec_rs1 = 5'd9;
        half1();
        check("midrst_ready", 32'(bus.mc_ready), 32'd1);
        check("midrst_hazard", 32'(bus.hazard), 32'd0);
        check("midrst_no_drain", 32'(bus.rf_we), 32'd0);
        half2();
        idle_inputs();
        repeat (2) cyc();

        // Randomized traffic; WB contents are held whenever the model predicts a hold.
        for (int i = 0; i < 600; i++) begin
            if (!m_hold_prev) begin
                bus.wb_valid = ($urandom_range(0, 99) < 70);
                bus.wb_rd = 5'($urandom);
                bus.wb_data = $urandom;
            end
            bus.mc_valid = ($urandom_range(0, 99) < 35);
            bus.mc_rd = 5'($urandom);
            bus.mc_data = $urandom;
            bus.iss_valid = ($urandom_range(0, 99) < 25);
            bus.iss_rd = 5'($urandom);
            bus.dec_rs1 = 5'($urandom);
            bus.dec_rs2 = 5'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 0;
        idle_inputs();
        repeat (4) cyc();

        check("writes_outstanding", 32'(wr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
